// File: rtl/fir_ctrl_if.sv
// Command byte channel into the FIR controller.
// Valid/ready handshake; a byte moves when both are high.
interface fir_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/fir_ctrl.sv
// FIR command controller: tap writes, delay-line clear,
// and a programmable sample-enable divider.
module fir_ctrl #(
  parameter int NTAPS       = 8,
  parameter int ADDR_W      = $clog2(NTAPS),
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  fir_ctrl_if.slave         cfg,
  output logic              sample_en,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [7:0]        coef_data,
  output logic              fir_clear,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    GET_ARG,
    WRITE
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [5:0]       arg_q;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;

  logic       acc;
  logic [1:0] hop;
  logic       stall;
  logic       cnt_rst;

  assign acc = cfg.cfg_valid & cfg.cfg_ready;
  assign hop = cfg.cfg_data[7:6];

  // Freeze the divider for the whole tap update, starting at header accept,
  // and restart it on a new divisor or a clear.
  always_comb begin
    stall   = 1'b0;
    cnt_rst = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        stall   = acc && hop == OP_LOAD;
        cnt_rst = acc && hop == OP_CLR;
      end
      state == GET_ARG: begin
        stall   = op_q == OP_LOAD;
        cnt_rst = acc && op_q == OP_DIV;
      end
      state == WRITE: stall = 1'b1;
      default: ;
    endcase
  end

  // Command FSM; every output is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= OP_NOP;
      arg_q         <= '0;
      div_reg       <= DIV_W'(DEFAULT_DIV);
      cfg.cfg_ready <= 1'b0;
      busy          <= 1'b0;
      coef_we       <= 1'b0;
      coef_addr     <= '0;
      coef_data     <= '0;
      fir_clear     <= 1'b0;
      err           <= 1'b0;
    end else begin
      coef_we   <= 1'b0;
      fir_clear <= 1'b0;
      unique case (state)
        IDLE: begin
          cfg.cfg_ready <= 1'b1;
          busy          <= 1'b0;
          if (acc) begin
            unique case (hop)
              OP_DIV, OP_LOAD: begin
                op_q  <= hop;
                arg_q <= cfg.cfg_data[5:0];
                busy  <= 1'b1;
                state <= GET_ARG;
              end
              OP_CLR: begin
                fir_clear <= 1'b1;
                err       <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        GET_ARG: begin
          if (acc) begin
            if (op_q == OP_DIV) begin
              div_reg <= cfg.cfg_data;
              busy    <= 1'b0;
              state   <= IDLE;
            end else if (int'(arg_q) < NTAPS) begin
              coef_addr     <= arg_q[ADDR_W-1:0];
              coef_data     <= cfg.cfg_data;
              coef_we       <= 1'b1;
              cfg.cfg_ready <= 1'b0;
              state         <= WRITE;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          cfg.cfg_ready <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample divider: one-cycle pulse every div_reg+1 running cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sample_en <= 1'b0;
    end else if (cnt_rst) begin
      cnt       <= '0;
      sample_en <= 1'b0;
    end else if (stall) begin
      sample_en <= 1'b0;
    end else if (cnt == div_reg) begin
      cnt       <= '0;
      sample_en <= 1'b1;
    end else begin
      cnt       <= cnt + 1'b1;
      sample_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: directed command scenarios plus random
// byte traffic, checked against a transaction-level model.
module tb_fir_ctrl;

  localparam int NTAPS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en, coef_we, fir_clear, busy, err;
  logic [2:0] coef_addr;
  logic [7:0] coef_data;

  fir_ctrl_if cfg ();

  fir_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg),
    .sample_en (sample_en),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .fir_clear (fir_clear),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit         m_ready, m_sen, m_we, m_clr, m_busy, m_err, m_wr;
  logic [2:0] m_addr;
  logic [7:0] m_data;
  int         m_pend, m_tap, m_div, m_phase;

  function automatic logic [16:0] dut_vec();
    return {cfg.cfg_ready, sample_en, coef_we, coef_addr,
            coef_data, fir_clear, busy, err};
  endfunction

  function automatic logic [16:0] mdl_vec();
    return {m_ready, m_sen, m_we, m_addr,
            m_data, m_clr, m_busy, m_err};
  endfunction

  task automatic model_reset();
    m_ready = 0; m_sen = 0; m_we = 0; m_clr = 0;
    m_busy = 0; m_err = 0; m_wr = 0;
    m_addr = '0; m_data = '0;
    m_pend = 0; m_tap = 0; m_div = 0; m_phase = 0;
  endtask

  // One clock: drive a byte, advance the model on the edge.
  task automatic tick(input bit v, input logic [7:0] d, output bit acc);
    bit stall, rph;
    int op;
    cfg.cfg_valid = v;
    cfg.cfg_data  = d;
    @(posedge clk);
    acc   = v && m_ready;
    op    = int'(d[7:6]);
    stall = m_wr || m_pend == 2 || (m_pend == 0 && acc && op == 2);
    rph   = 0;
    m_we  = 0;
    m_clr = 0;
    if (m_wr) begin
      m_wr = 0;
    end else if (acc && m_pend == 0) begin
      if (op == 1 || op == 2) begin
        m_pend = op;
        m_tap  = int'(d[5:0]);
      end else if (op == 3) begin
        m_clr = 1; m_err = 0; rph = 1;
      end
    end else if (acc) begin
      if (m_pend == 1) begin
        m_div = int'(d); rph = 1;
      end else if (m_tap < NTAPS) begin
        m_addr = 3'(m_tap); m_data = d; m_wr = 1; m_we = 1;
      end else begin
        m_err = 1;
      end
      m_pend = 0;
    end
    if (rph) begin
      m_sen = 0; m_phase = 0;
    end else if (!stall) begin
      m_sen   = (m_phase == m_div);
      m_phase = (m_phase + 1) % (m_div + 1);
    end else begin
      m_sen = 0;
    end
    m_busy  = m_pend != 0 || m_wr;
    m_ready = !m_wr;
    #1;
  endtask

  task automatic test_reset();
    bit acc;
    rst_n = 0;
    cfg.cfg_valid = 0;
    cfg.cfg_data  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (dut_vec() !== 17'h0) begin
      $display("FAIL reset_state: got %h want %h", dut_vec(), 17'h0);
      fails++;
    end
    @(negedge clk) rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick(0, 8'($urandom), acc);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL reset_run c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
      tests++;
      if (sample_en !== 1'b1) begin
        $display("FAIL div0_strobe c%0d: got %b want 1", c, sample_en);
        fails++;
      end
    end
  endtask

  task automatic test_set_div();
    bit acc, v;
    logic [7:0] q[$];
    int ta = -1, first = -1, second = -1;
    q = '{8'h40, 8'h03};
    for (int c = 0; c < 16; c++) begin
      v = q.size() != 0;
      tick(v, v ? q[0] : 8'($urandom), acc);
      if (acc) begin
        void'(q.pop_front());
        if (q.size() == 0) ta = c;
      end
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL set_div c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
      if (ta >= 0 && c > ta && sample_en === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    tests++;
    if (first != ta + 4) begin
      $display("FAIL set_div_first: got %0d want %0d", first, ta + 4);
      fails++;
    end
    tests++;
    if (second != ta + 8) begin
      $display("FAIL set_div_period: got %0d want %0d", second, ta + 8);
      fails++;
    end
  endtask

  task automatic test_load_coef();
    bit acc, v, win = 0;
    logic [7:0] q[$];
    int nwe = 0, viol = 0;
    q = '{8'h85, 8'h7F};
    for (int c = 0; c < 16; c++) begin
      v = q.size() != 0;
      tick(v, v ? q[0] : 8'($urandom), acc);
      if (acc) begin
        void'(q.pop_front());
        if (q.size() == 1) win = 1;
      end
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL load c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
      if (win && sample_en !== 1'b0) viol++;
      if (coef_we === 1'b1) begin
        nwe++;
        win = 0;
        tests++;
        if ({cfg.cfg_ready, coef_addr, coef_data} !== {1'b0, 3'd5, 8'h7F}) begin
          $display("FAIL load_write: got %h want %h",
                   {cfg.cfg_ready, coef_addr, coef_data}, {1'b0, 3'd5, 8'h7F});
          fails++;
        end
      end
    end
    tests++;
    if (nwe != 1) begin
      $display("FAIL load_we_count: got %0d want 1", nwe);
      fails++;
    end
    tests++;
    if (viol != 0) begin
      $display("FAIL load_stall: got %0d strobes want 0", viol);
      fails++;
    end
  endtask

  task automatic test_bad_tap_clear();
    bit acc, v;
    logic [7:0] q[$];
    int nwe = 0, tc = -1, first = -1;
    q = '{8'h88, 8'h11};
    for (int c = 0; c < 8; c++) begin
      v = q.size() != 0;
      tick(v, v ? q[0] : 8'($urandom), acc);
      if (acc) void'(q.pop_front());
      if (coef_we === 1'b1) nwe++;
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL bad_tap c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
    end
    tests++;
    if (err !== 1'b1 || nwe != 0) begin
      $display("FAIL bad_tap_err: got err=%b we=%0d want err=1 we=0", err, nwe);
      fails++;
    end
    q = '{8'hC0};
    for (int c = 0; c < 12; c++) begin
      v = q.size() != 0;
      tick(v, v ? q[0] : 8'($urandom), acc);
      if (acc) begin
        void'(q.pop_front());
        tc = c;
        tests++;
        if ({fir_clear, err} !== 2'b10) begin
          $display("FAIL clear_pulse: got %b want 10", {fir_clear, err});
          fails++;
        end
      end
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL clear c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
      if (tc >= 0 && c > tc && sample_en === 1'b1 && first < 0) first = c;
    end
    tests++;
    if (first != tc + 4) begin
      $display("FAIL clear_restart: got %0d want %0d", first, tc + 4);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    bit acc, v, got_hdr = 0;
    logic [7:0] q[$];
    int nwe = 0;
    for (int c = 0; c < 4 && !got_hdr; c++) begin
      tick(1, 8'h85, acc);
      got_hdr = acc;
    end
    tests++;
    if (!got_hdr || busy !== 1'b1) begin
      $display("FAIL mid_hdr: got acc=%b busy=%b want 1 1", got_hdr, busy);
      fails++;
    end
    rst_n = 0;
    cfg.cfg_valid = 0;
    model_reset();
    #1;
    tests++;
    if (dut_vec() !== 17'h0) begin
      $display("FAIL mid_reset: got %h want %h", dut_vec(), 17'h0);
      fails++;
    end
    @(negedge clk) rst_n = 1;
    q = '{8'h83, 8'h55};
    for (int c = 0; c < 12; c++) begin
      v = q.size() != 0;
      tick(v, v ? q[0] : 8'($urandom), acc);
      if (acc) void'(q.pop_front());
      if (c == 0) begin
        tests++;
        if (sample_en !== 1'b1) begin
          $display("FAIL mid_default_div: got %b want 1", sample_en);
          fails++;
        end
      end
      if (coef_we === 1'b1) begin
        nwe++;
        tests++;
        if ({coef_addr, coef_data} !== {3'd3, 8'h55}) begin
          $display("FAIL mid_write: got %h want %h",
                   {coef_addr, coef_data}, {3'd3, 8'h55});
          fails++;
        end
      end
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL mid c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
    end
    tests++;
    if (nwe != 1) begin
      $display("FAIL mid_we_count: got %0d want 1", nwe);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    bit acc, v;
    logic [7:0] q[$];
    int nwe = 0, nacc = 0, nrdy = 0, done = -1;
    q = '{8'h00, 8'h40, 8'h00, 8'h81, 8'h22};
    for (int c = 0; c < 14; c++) begin
      v = q.size() != 0;
      tick(v, v ? q[0] : 8'($urandom), acc);
      if (acc) begin
        void'(q.pop_front());
        nacc++;
        if (q.size() == 0) done = c;
      end
      if (cfg.cfg_ready !== 1'b1) nrdy++;
      if (coef_we === 1'b1) begin
        nwe++;
        tests++;
        if ({coef_addr, coef_data} !== {3'd1, 8'h22}) begin
          $display("FAIL b2b_write: got %h want %h",
                   {coef_addr, coef_data}, {3'd1, 8'h22});
          fails++;
        end
      end
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL b2b c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
    end
    tests++;
    if (nacc != 5 || done != 4) begin
      $display("FAIL b2b_accept: got %0d by %0d want 5 by 4", nacc, done);
      fails++;
    end
    tests++;
    if (nwe != 1 || nrdy != 1) begin
      $display("FAIL b2b_we_rdy: got we=%0d nrdy=%0d want 1 1", nwe, nrdy);
      fails++;
    end
  endtask

  task automatic test_random();
    bit acc, v;
    logic [7:0] d;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom % 3) != 0;
      d = 8'($urandom);
      if (d[7:6] == 2'b01 && ($urandom % 4) != 0) d = 8'h40;
      tick(v, d, acc);
      if (m_pend == 1 && acc) begin
        tick(1, 8'($urandom % 6), acc);
      end
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL random c%0d: got %h want %h", c, dut_vec(), mdl_vec());
        fails++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_set_div();
    test_load_coef();
    test_bad_tap_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
